// File: rtl/nand_cmd_seq_pkg.sv
// Shared encodings for the NAND command sequencer and flash_ctrl: mode codes,
// operation codes, ONFI opcodes and instruction word layout.
package nand_pkg;

   localparam logic [7:0] MODE_STANDBY  = 8'd0;
   localparam logic [7:0] MODE_BUS_IDLE = 8'd1;
   localparam logic [7:0] MODE_CMD      = 8'd2;
   localparam logic [7:0] MODE_ADDR     = 8'd3;
   localparam logic [7:0] MODE_DIN      = 8'd4;
   localparam logic [7:0] MODE_DOUT     = 8'd5;
   localparam logic [7:0] MODE_DOUT_END = 8'd6;
   localparam logic [7:0] MODE_WP       = 8'd7;

   localparam logic [2:0] OP_RESET        = 3'd0;
   localparam logic [2:0] OP_READ_STATUS  = 3'd1;
   localparam logic [2:0] OP_READ_PAGE    = 3'd2;
   localparam logic [2:0] OP_PROGRAM_PAGE = 3'd3;
   localparam logic [2:0] OP_ERASE_BLOCK  = 3'd4;

   localparam logic [7:0] ONFI_READ1  = 8'h00;
   localparam logic [7:0] ONFI_READ2  = 8'h30;
   localparam logic [7:0] ONFI_PROG1  = 8'h80;
   localparam logic [7:0] ONFI_PROG2  = 8'h10;
   localparam logic [7:0] ONFI_ERASE1 = 8'h60;
   localparam logic [7:0] ONFI_ERASE2 = 8'hD0;
   localparam logic [7:0] ONFI_STATUS = 8'h70;
   localparam logic [7:0] ONFI_RESET  = 8'hFF;

   localparam int INSTR_MODE_LSB = 0;
   localparam int INSTR_RPT_LSB  = 8;

   typedef enum logic {SRC_FIXED, SRC_HOST} src_e;

   function automatic logic [31:0] mk_instr(input logic [7:0] mode, input logic [11:0] rpt);
      logic [31:0] w;
      w = '0;
      w[INSTR_MODE_LSB +: 8] = mode;
      w[INSTR_RPT_LSB +: 12] = rpt;
      return w;
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_ERASE_BLOCK);
   endfunction

endpackage

// File: rtl/nand_cmd_seq_if.sv
// Request, host payload and FIFO write-port signals of the NAND command sequencer.
interface nand_cmd_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [23:0] req_row;
   logic [15:0] req_col;
   logic [7:0]  host_data;
   logic        host_valid;
   logic        host_ready;
   logic [31:0] instr_data;
   logic        instr_wr;
   logic        instr_full;
   logic [7:0]  byte_data;
   logic        byte_wr;
   logic        byte_full;
   logic        busy;
   logic        done;
   logic        err;

   modport slave (
      input  req_valid, req_op, req_row, req_col, host_data, host_valid, instr_full, byte_full,
      output req_ready, host_ready, instr_data, instr_wr, byte_data, byte_wr, busy, done, err
   );

   modport master (
      output req_valid, req_op, req_row, req_col, host_data, host_valid, instr_full, byte_full,
      input  req_ready, host_ready, instr_data, instr_wr, byte_data, byte_wr, busy, done, err
   );
endinterface

// File: rtl/nand_cmd_seq_seg_rom.sv
// Segment table: maps (op, segment, byte index) to the instruction fields and
// the byte to push for that segment.
module nand_seg_rom
   import nand_pkg::*;
#(
   parameter int         PAGE_BYTES = 2048,
   parameter logic [7:0] IDLEDATA   = 8'hAA
) (
   input  logic [2:0]  op_i,
   input  logic [2:0]  seg_i,
   input  logic [23:0] row_i,
   input  logic [15:0] col_i,
   input  logic [2:0]  idx_i,
   output logic [7:0]  mode_o,
   output logic [11:0] rpt_o,
   output src_e        src_o,
   output logic [7:0]  val_o,
   output logic        last_o
);

   localparam logic [11:0] RPT_DOUT = 12'(PAGE_BYTES - 2);
   localparam logic [11:0] RPT_DIN  = 12'(PAGE_BYTES - 1);

   logic [7:0] page_addr;
   logic [7:0] blk_addr;

   always_comb begin
      case (idx_i)
         3'd0:    page_addr = col_i[7:0];
         3'd1:    page_addr = col_i[15:8];
         3'd2:    page_addr = row_i[7:0];
         3'd3:    page_addr = row_i[15:8];
         default: page_addr = row_i[23:16];
      endcase
      case (idx_i)
         3'd0:    blk_addr = row_i[7:0];
         3'd1:    blk_addr = row_i[15:8];
         default: blk_addr = row_i[23:16];
      endcase
   end

   // Non-host, non-command segments push IDLEDATA as the read pacing token.
   always_comb begin
      mode_o = MODE_STANDBY;
      rpt_o  = '0;
      src_o  = SRC_FIXED;
      val_o  = IDLEDATA;
      last_o = 1'b1;
      case (op_i)
         OP_RESET: begin
            mode_o = MODE_CMD;
            val_o  = ONFI_RESET;
         end
         OP_READ_STATUS: begin
            if (seg_i == 3'd0) begin
               mode_o = MODE_CMD;
               val_o  = ONFI_STATUS;
               last_o = 1'b0;
            end else begin
               mode_o = MODE_DOUT_END;
            end
         end
         OP_READ_PAGE: begin
            last_o = 1'b0;
            case (seg_i)
               3'd0: begin mode_o = MODE_CMD;  val_o = ONFI_READ1; end
               3'd1: begin mode_o = MODE_ADDR; rpt_o = 12'd4; val_o = page_addr; end
               3'd2: begin mode_o = MODE_CMD;  val_o = ONFI_READ2; end
               3'd3: begin mode_o = MODE_DOUT; rpt_o = RPT_DOUT; end
               default: begin mode_o = MODE_DOUT_END; last_o = 1'b1; end
            endcase
         end
         OP_PROGRAM_PAGE: begin
            last_o = 1'b0;
            case (seg_i)
               3'd0: begin mode_o = MODE_CMD;  val_o = ONFI_PROG1; end
               3'd1: begin mode_o = MODE_ADDR; rpt_o = 12'd4; val_o = page_addr; end
               3'd2: begin mode_o = MODE_DIN;  rpt_o = RPT_DIN; src_o = SRC_HOST; end
               default: begin mode_o = MODE_CMD; val_o = ONFI_PROG2; last_o = 1'b1; end
            endcase
         end
         OP_ERASE_BLOCK: begin
            last_o = 1'b0;
            case (seg_i)
               3'd0: begin mode_o = MODE_CMD;  val_o = ONFI_ERASE1; end
               3'd1: begin mode_o = MODE_ADDR; rpt_o = 12'd2; val_o = blk_addr; end
               default: begin mode_o = MODE_CMD; val_o = ONFI_ERASE2; last_o = 1'b1; end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/nand_cmd_seq.sv
// Turns one NAND operation request into instruction words and command/address/
// payload bytes for flash_ctrl's FIFOs, one segment at a time.
//   state    | meaning
//   ST_IDLE  | waiting for a request, req_ready high
//   ST_INSTR | pushing the current segment's instruction word
//   ST_BYTES | pushing the segment's r+1 bytes, counter counts down to 0
//   ST_FIN   | one-cycle done (and err for an illegal op)
module nand_cmd_seq
   import nand_pkg::*;
#(
   parameter int         PAGE_BYTES = 2048,
   parameter logic [7:0] IDLEDATA   = 8'hAA
) (
   input logic          clk,
   input logic          rst,
   nand_cmd_seq_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_BYTES, ST_FIN} state_e;

   state_e      state_q;
   logic        run_q;
   logic        err_q;
   logic [2:0]  op_q;
   logic [2:0]  seg_q;
   logic [23:0] row_q;
   logic [15:0] col_q;
   logic [11:0] cnt_q;

   logic [7:0]  rom_mode;
   logic [11:0] rom_rpt;
   src_e        rom_src;
   logic [7:0]  rom_val;
   logic        rom_last;
   logic [2:0]  byte_idx;
   logic        host_seg;
   logic        instr_push;
   logic        byte_push;

   // Address bytes go out in index order while the counter runs down from r.
   assign byte_idx = rom_rpt[2:0] - cnt_q[2:0];

   nand_seg_rom #(
      .PAGE_BYTES (PAGE_BYTES),
      .IDLEDATA   (IDLEDATA)
   ) u_seg_rom (
      .op_i   (op_q),
      .seg_i  (seg_q),
      .row_i  (row_q),
      .col_i  (col_q),
      .idx_i  (byte_idx),
      .mode_o (rom_mode),
      .rpt_o  (rom_rpt),
      .src_o  (rom_src),
      .val_o  (rom_val),
      .last_o (rom_last)
   );

   always_comb begin
      host_seg   = (rom_src == SRC_HOST);
      instr_push = (state_q == ST_INSTR) && !bus.instr_full;
      byte_push  = (state_q == ST_BYTES) && !bus.byte_full && (!host_seg || bus.host_valid);
   end

   assign bus.req_ready  = run_q && (state_q == ST_IDLE);
   assign bus.instr_wr   = instr_push;
   assign bus.byte_wr    = byte_push;
   assign bus.host_ready = (state_q == ST_BYTES) && host_seg && !bus.byte_full;
   assign bus.instr_data = (state_q == ST_INSTR) ? mk_instr(rom_mode, rom_rpt) : '0;
   assign bus.byte_data  = (state_q != ST_BYTES) ? IDLEDATA :
                           host_seg ? bus.host_data : rom_val;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_FIN);
   assign bus.err        = (state_q == ST_FIN) && err_q;

   // run_q keeps req_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
         op_q    <= '0;
         seg_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid && run_q) begin
                  op_q  <= bus.req_op;
                  row_q <= bus.req_row;
                  col_q <= bus.req_col;
                  seg_q <= '0;
                  if (op_legal(bus.req_op)) begin
                     err_q   <= 1'b0;
                     state_q <= ST_INSTR;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_INSTR: begin
               if (instr_push) begin
                  cnt_q   <= rom_rpt;
                  state_q <= ST_BYTES;
               end
            end
            ST_BYTES: begin
               if (byte_push) begin
                  if (cnt_q != 12'd0) begin
                     cnt_q <= cnt_q - 12'd1;
                  end else if (rom_last) begin
                     state_q <= ST_FIN;
                  end else begin
                     seg_q   <= seg_q + 3'd1;
                     state_q <= ST_INSTR;
                  end
               end
            end
            ST_FIN:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Directed bench for nand_cmd_seq: each operation's pushed words/bytes, latency,
// full/host stalls, illegal op and asynchronous reset.
module tb_nand_cmd_seq;
   import nand_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   nand_cmd_seq_if bus ();

   nand_cmd_seq #(
      .PAGE_BYTES (2048),
      .IDLEDATA   (8'hAA)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int full_viol   = 0;

   logic [31:0] iq[$];
   logic [7:0]  bq[$];

   always @(negedge clk) begin
      if (rst) begin
         if (bus.instr_wr) begin
            iq.push_back(bus.instr_data);
            if (bus.instr_full) full_viol++;
         end
         if (bus.byte_wr) begin
            bq.push_back(bus.byte_data);
            if (bus.byte_full) full_viol++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] qi(input int i);
      return (iq.size() > i) ? iq[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [7:0] qb(input int i);
      return (bq.size() > i) ? bq[i] : 8'hXX;
   endfunction

   function automatic logic [7:0] hpat(input int k);
      return 8'(k * 7 + 3) ^ 8'(k >> 8);
   endfunction

   task automatic send_req(input logic [2:0] op, input logic [23:0] row, input logic [15:0] col);
      int n;
      @(posedge clk); #1;
      bus.req_op    = op;
      bus.req_row   = row;
      bus.req_col   = col;
      bus.req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd5;
      bus.req_row   = '1;
      bus.req_col   = '1;
   endtask

   // Runs one operation to done; cyc counts cycles from accept edge to done.
   task automatic run_op(input logic [2:0] op, input logic [23:0] row, input logic [15:0] col,
                         input bit stall_en, input bit gap_en,
                         output int cyc, output logic err_at_done, output int hk);
      int  gapleft;
      bit  acc;
      bit  in_gap;
      bit  seen;
      iq.delete();
      bq.delete();
      hk             = 0;
      gapleft        = gap_en ? 5 : 0;
      bus.host_valid = 1'b1;
      bus.host_data  = hpat(0);
      send_req(op, row, col);
      seen        = 1'b0;
      cyc         = 0;
      err_at_done = 1'b0;
      for (int c = 0; c < 5000 && !seen; c++) begin
         bus.byte_full = stall_en && (c >= 4) && (c < 14);
         if (gap_en && hk == 1000 && gapleft > 0) begin
            bus.host_valid = 1'b0;
            gapleft--;
            in_gap = 1'b1;
         end else begin
            bus.host_valid = 1'b1;
            in_gap = 1'b0;
         end
         bus.host_data = hpat(hk);
         @(negedge clk);
         if (bus.byte_full) begin
            chk("stall_no_push", 32'(bus.byte_wr), 32'd0);
            chk("stall_byte_held", 32'(bus.byte_data), 32'(col[15:8]));
         end
         if (in_gap) begin
            chk("gap_host_ready", 32'(bus.host_ready), 32'd1);
            chk("gap_no_push", 32'(bus.byte_wr), 32'd0);
         end
         acc = bus.host_ready && bus.host_valid;
         if (bus.done) begin
            seen        = 1'b1;
            cyc         = c + 1;
            err_at_done = bus.err;
         end
         @(posedge clk); #1;
         if (acc) hk++;
      end
      bus.byte_full  = 1'b0;
      bus.host_valid = 1'b0;
      chk("done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("ready_after_done", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      int   cyc;
      int   hk;
      int   bad;
      logic e;
      logic [7:0] rp_head [7];

      bus.req_valid  = 1'b0;
      bus.req_op     = '0;
      bus.req_row    = '0;
      bus.req_col    = '0;
      bus.host_data  = '0;
      bus.host_valid = 1'b0;
      bus.instr_full = 1'b0;
      bus.byte_full  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_instr_wr", 32'(bus.instr_wr), 32'd0);
      chk("rst_byte_wr", 32'(bus.byte_wr), 32'd0);
      chk("rst_host_ready", 32'(bus.host_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_instr_data", bus.instr_data, 32'd0);
      chk("rst_byte_data", 32'(bus.byte_data), 32'hAA);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_release", 32'(bus.req_ready), 32'd1);

      // RESET
      run_op(OP_RESET, 24'h0, 16'h0, 1'b0, 1'b0, cyc, e, hk);
      chk("reset_latency", 32'(cyc), 32'd3);
      chk("reset_err", 32'(e), 32'd0);
      chk("reset_ninstr", 32'(iq.size()), 32'd1);
      chk("reset_instr0", qi(0), 32'h0000_0002);
      chk("reset_nbytes", 32'(bq.size()), 32'd1);
      chk("reset_byte0", 32'(qb(0)), 32'hFF);

      // READ_STATUS
      run_op(OP_READ_STATUS, 24'h0, 16'h0, 1'b0, 1'b0, cyc, e, hk);
      chk("rs_latency", 32'(cyc), 32'd5);
      chk("rs_ninstr", 32'(iq.size()), 32'd2);
      chk("rs_instr0", qi(0), 32'h0000_0002);
      chk("rs_instr1", qi(1), 32'h0000_0006);
      chk("rs_byte0", 32'(qb(0)), 32'h70);
      chk("rs_byte1", 32'(qb(1)), 32'hAA);

      // READ_PAGE row=0x123456 col=0x0010
      run_op(OP_READ_PAGE, 24'h123456, 16'h0010, 1'b0, 1'b0, cyc, e, hk);
      chk("rp_latency", 32'(cyc), 32'd2061);
      chk("rp_err", 32'(e), 32'd0);
      chk("rp_ninstr", 32'(iq.size()), 32'd5);
      chk("rp_instr0", qi(0), 32'h0000_0002);
      chk("rp_instr1", qi(1), 32'h0000_0403);
      chk("rp_instr2", qi(2), 32'h0000_0002);
      chk("rp_instr3", qi(3), 32'h0007_FE05);
      chk("rp_instr4", qi(4), 32'h0000_0006);
      chk("rp_nbytes", 32'(bq.size()), 32'd2055);
      rp_head = '{8'h00, 8'h10, 8'h00, 8'h56, 8'h34, 8'h12, 8'h30};
      bad = 0;
      for (int i = 0; i < 7; i++) if (qb(i) !== rp_head[i]) bad++;
      chk("rp_cmd_addr_bytes", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 7; i < 2055; i++) if (qb(i) !== 8'hAA) bad++;
      chk("rp_tokens", 32'(bad), 32'd0);

      // PROGRAM_PAGE with byte_full in ADDR and a host_valid gap mid-page
      run_op(OP_PROGRAM_PAGE, 24'hABCDEF, 16'h0123, 1'b1, 1'b1, cyc, e, hk);
      chk("pp_latency", 32'(cyc), 32'd2075);
      chk("pp_host_count", 32'(hk), 32'd2048);
      chk("pp_ninstr", 32'(iq.size()), 32'd4);
      chk("pp_instr0", qi(0), 32'h0000_0002);
      chk("pp_instr1", qi(1), 32'h0000_0403);
      chk("pp_instr2", qi(2), 32'h0007_FF04);
      chk("pp_instr3", qi(3), 32'h0000_0002);
      chk("pp_nbytes", 32'(bq.size()), 32'd2055);
      chk("pp_byte0", 32'(qb(0)), 32'h80);
      chk("pp_addr0", 32'(qb(1)), 32'h23);
      chk("pp_addr1", 32'(qb(2)), 32'h01);
      chk("pp_addr2", 32'(qb(3)), 32'hEF);
      chk("pp_addr3", 32'(qb(4)), 32'hCD);
      chk("pp_addr4", 32'(qb(5)), 32'hAB);
      bad = 0;
      for (int j = 0; j < 2048; j++) if (qb(6 + j) !== hpat(j)) bad++;
      chk("pp_payload", 32'(bad), 32'd0);
      chk("pp_last_cmd", 32'(qb(2054)), 32'h10);

      // ERASE_BLOCK row=0x0000FF
      run_op(OP_ERASE_BLOCK, 24'h0000FF, 16'hBEEF, 1'b0, 1'b0, cyc, e, hk);
      chk("er_latency", 32'(cyc), 32'd9);
      chk("er_ninstr", 32'(iq.size()), 32'd3);
      chk("er_instr1", qi(1), 32'h0000_0203);
      chk("er_instr2", qi(2), 32'h0000_0002);
      chk("er_nbytes", 32'(bq.size()), 32'd5);
      chk("er_bytes", {qb(0), qb(1), qb(2), qb(3)}, 32'h60FF_0000);
      chk("er_byte4", 32'(qb(4)), 32'hD0);

      // illegal op
      run_op(3'd6, 24'h0, 16'h0, 1'b0, 1'b0, cyc, e, hk);
      chk("ill_latency", 32'(cyc), 32'd1);
      chk("ill_err", 32'(e), 32'd1);
      chk("ill_ninstr", 32'(iq.size()), 32'd0);
      chk("ill_nbytes", 32'(bq.size()), 32'd0);

      // asynchronous reset mid READ_PAGE
      send_req(OP_READ_PAGE, 24'h000001, 16'h0000);
      repeat (30) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      chk("pre_rst_byte_wr", 32'(bus.byte_wr), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_byte_wr", 32'(bus.byte_wr), 32'd0);
      chk("arst_instr_wr", 32'(bus.instr_wr), 32'd0);
      chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("arst_byte_data", 32'(bus.byte_data), 32'hAA);
      chk("arst_instr_data", bus.instr_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_op(OP_RESET, 24'h0, 16'h0, 1'b0, 1'b0, cyc, e, hk);
      chk("post_rst_latency", 32'(cyc), 32'd3);
      chk("post_rst_instr0", qi(0), 32'h0000_0002);
      chk("post_rst_byte0", 32'(qb(0)), 32'hFF);
      chk("post_rst_nbytes", 32'(bq.size()), 32'd1);

      chk("no_push_when_full", 32'(full_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
